wishbone_master_adapter: RTL and testbench
==========================================

WISHBONE_MASTER_ADAPTER -- requirements
Module: wishbone_master_adapter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 255, max BUS-state cycles without wb_ack_i before abort (legal range 1..65535).
REQ-002 SHALL have ports:
- clk_i  input  1  single clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- cpu_req_i  input  1  request strobe; sampled only in IDLE.
- cpu_we_i  input  1  1 = write, 0 = read.
- cpu_addr_i  input  32  byte address.
- cpu_wdata_i  input  32  write data.
- cpu_sel_i  input  4  byte select.
- cpu_rdata_o  output  32  read data, registered.
- cpu_done_o  output  1  one-cycle completion pulse.
- cpu_err_o  output  1  one-cycle timeout flag, coincident with cpu_done_o.
- cpu_busy_o  output  1  high whenever state != IDLE.
- wb_addr_o  output  32  Wishbone address.
- wb_data_o  output  32  Wishbone write data.
- wb_data_i  input  32  Wishbone read data.
- wb_we_o  output  1  Wishbone write enable.
- wb_sel_o  output  4  Wishbone byte select.
- wb_stb_o  output  1  Wishbone strobe.
- wb_cyc_o  output  1  Wishbone cycle.
- wb_ack_i  input  1  Wishbone acknowledge.

Function
REQ-003 SHALL implement FSM with states IDLE, BUS, DONE; all outputs registered or decoded from state only.
REQ-004 SHALL, in IDLE with cpu_req_i=1, latch cpu_addr_i/cpu_wdata_i/cpu_we_i/cpu_sel_i into wb_addr_o/wb_data_o/wb_we_o/wb_sel_o, clear timeout counter, go to BUS next edge.
REQ-005 SHALL drive wb_cyc_o=wb_stb_o=1 exactly while in BUS; 0 in IDLE and DONE.
REQ-006 SHALL hold wb_addr_o, wb_data_o, wb_we_o, wb_sel_o stable from BUS entry until next accepted request.
REQ-007 SHALL ignore cpu_req_i and all CPU inputs while in BUS or DONE; no queueing.
REQ-008 SHALL, in BUS with wb_ack_i=1, go to DONE with err flag 0; on reads (wb_we_o=0) capture wb_data_i into cpu_rdata_o at the same edge; on writes leave cpu_rdata_o unchanged.
REQ-009 SHALL increment 16-bit timeout counter each BUS cycle with wb_ack_i=0; when counter equals TIMEOUT_CYCLES-1 and wb_ack_i=0, go to DONE with err flag 1, cpu_rdata_o unchanged.
REQ-010 SHALL give wb_ack_i priority over timeout when both occur in the same cycle (success, err 0).
REQ-011 SHALL assert cpu_done_o=1 for exactly the single DONE cycle, cpu_err_o=err flag during that cycle, both 0 otherwise; DONE always returns to IDLE next edge.
REQ-012 SHALL ignore wb_ack_i in IDLE and DONE (a slave holding ack or a late ack causes no second completion).
REQ-013 SHALL give latency: cpu_req_i sampled at edge N -> stb high N+1..; ack sampled at edge M -> cpu_done_o high for cycle M+1; minimum request-to-done 2 cycles after acceptance; back-to-back requests accepted no sooner than the IDLE cycle following DONE.
REQ-014 SHALL treat illegal state encodings as IDLE on next edge.

Reset
REQ-015 SHALL, on rst=1 at a clock edge, set state IDLE, timeout counter 0, err flag 0, and all outputs 0 (wb_*_o, cpu_rdata_o, cpu_done_o, cpu_err_o, cpu_busy_o).
REQ-016 SHALL, when reset is asserted mid-transaction (BUS or DONE), drop wb_cyc_o/wb_stb_o at that edge and produce no cpu_done_o pulse for the aborted transaction.
REQ-017 SHALL ignore cpu_req_i in any cycle where rst=1.

Verification
REQ-018 Read: req we=0 addr=0x1000_0004 sel=0xF; slave acks after 1 BUS cycle with data 0xDEAD_BEEF -> cyc/stb high 2 cycles, cpu_done_o 1 cycle, cpu_rdata_o=0xDEAD_BEEF, cpu_err_o=0.
REQ-019 Write: req we=1 addr=0x1000_0008 wdata=0x0000_00A5 sel=0x1 to slave with ack-then-cooldown -> wb_data_o=0xA5, wb_we_o=1 during BUS, exactly one cpu_done_o, cpu_rdata_o unchanged.
REQ-020 Timeout: TIMEOUT_CYCLES=4, no ack -> stb high exactly 4 cycles, then cpu_done_o=cpu_err_o=1 one cycle, back to IDLE.
REQ-021 Ack on final timeout cycle (TIMEOUT_CYCLES=4, ack in 4th BUS cycle) -> cpu_err_o=0, read data captured.
REQ-022 Ack held 3 cycles by slave plus cpu_req_i held high continuously -> one done per transaction; second transaction starts only after IDLE cycle; stale ack in DONE ignored.
REQ-023 rst pulsed during BUS -> wb_cyc_o/wb_stb_o 0 after edge, no cpu_done_o, next request completes normally.

Source files
------------

// File: rtl/wishbone_master_adapter_if.sv
// Bundles the CPU-side request/response signals and the Wishbone master bus
// signals of the adapter. The "master" modport is the adapter's view; the
// "slave" modport is the view of whatever drives the CPU side and answers on
// the Wishbone side.
interface wishbone_master_adapter_if;
    logic        cpu_req_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_done_o;
    logic        cpu_err_o;
    logic        cpu_busy_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [31:0] wb_data_i;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    modport master (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_sel_i,
        output cpu_rdata_o, cpu_done_o, cpu_err_o, cpu_busy_o,
        output wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_data_i, wb_ack_i
    );

    modport slave (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_sel_i,
        input  cpu_rdata_o, cpu_done_o, cpu_err_o, cpu_busy_o,
        input  wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_data_i, wb_ack_i
    );
endinterface

// File: rtl/wishbone_master_adapter.sv
// Single-outstanding CPU-to-Wishbone master adapter. A request accepted in
// IDLE is presented on the bus in BUS until the slave acknowledges or the
// timeout counter expires, then DONE produces a one-cycle completion pulse.
module wishbone_master_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst,
    wishbone_master_adapter_if.master bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter value seen in the last BUS cycle allowed before giving up.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] tmo_cnt;
    logic        err_flag;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [3:0]  sel_q;

    // Request latch, bus-cycle sequencing, timeout counting and read capture.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state    <= ST_IDLE;
            tmo_cnt  <= 16'd0;
            err_flag <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            we_q     <= 1'b0;
            sel_q    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req_i) begin
                        addr_q  <= bus.cpu_addr_i;
                        wdata_q <= bus.cpu_wdata_i;
                        we_q    <= bus.cpu_we_i;
                        sel_q   <= bus.cpu_sel_i;
                        tmo_cnt <= 16'd0;
                        state   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus.wb_ack_i) begin
                        err_flag <= 1'b0;
                        state    <= ST_DONE;
                        if (!we_q) begin
                            rdata_q <= bus.wb_data_i;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_flag <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.wb_addr_o   = addr_q;
    assign bus.wb_data_o   = wdata_q;
    assign bus.wb_we_o     = we_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_cyc_o    = (state == ST_BUS);
    assign bus.wb_stb_o    = (state == ST_BUS);
    assign bus.cpu_rdata_o = rdata_q;
    assign bus.cpu_done_o  = (state == ST_DONE);
    assign bus.cpu_err_o   = (state == ST_DONE) && err_flag;
    assign bus.cpu_busy_o  = (state != ST_IDLE);

endmodule

// File: tb/tb_wishbone_master_adapter.sv
// Scoreboard bench for wishbone_master_adapter with a small timeout window.
// The driver also plays the Wishbone slave; expected completions are queued
// at issue time and a separate monitor compares them against the DUT.
module tb_wishbone_master_adapter;

    localparam int TMO = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        err;
        logic [31:0] rdata;
        int          bus_cycles;
    } exp_txn_t;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;

    exp_txn_t    exp_q[$];
    logic [31:0] model_rdata = 32'd0;
    int          stale_left  = 0;
    int          bus_count   = 0;
    int          checks      = 0;
    int          errors      = 0;

    wishbone_master_adapter_if bus_if();

    wishbone_master_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance to just after the next falling edge; a held slave ack expires here.
    task automatic stepNeg();
        @(negedge clk_i);
        #1;
        if (stale_left > 0) stale_left--;
        else bus_if.wb_ack_i = 1'b0;
    endtask

    // Issue one request and act as the slave until the adapter leaves BUS.
    // ack_cycle: BUS cycle (1-based) in which ack is given; values past the
    // window model a silent or late slave. hold: extra cycles ack stays high.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] sel,
                                 input logic [31:0] sdata, input int ack_cycle,
                                 input int hold, input int exp_wait, input bit req_high);
        exp_txn_t t;
        int  n;
        int  k;
        bit  acked;
        bus_if.cpu_req_i   = 1'b1;
        bus_if.cpu_we_i    = we;
        bus_if.cpu_addr_i  = addr;
        bus_if.cpu_wdata_i = wdata;
        bus_if.cpu_sel_i   = sel;
        acked        = (ack_cycle <= TMO);
        t.we         = we;
        t.addr       = addr;
        t.wdata      = wdata;
        t.sel        = sel;
        t.err        = !acked;
        t.bus_cycles = acked ? ack_cycle : TMO;
        t.rdata      = (acked && !we) ? sdata : model_rdata;
        model_rdata  = t.rdata;
        exp_q.push_back(t);
        n = 0;
        do begin
            stepNeg();
            n++;
        end while (!bus_if.wb_stb_o && n < 8);
        checkOutput("accept_latency", n, exp_wait);
        if (!bus_if.wb_stb_o) begin
            bus_if.cpu_req_i = 1'b0;
            return;
        end
        k = 1;
        while (bus_if.wb_stb_o && k <= 2 * TMO) begin
            bus_if.wb_ack_i    = (k == ack_cycle);
            bus_if.wb_data_i   = sdata;
            bus_if.cpu_req_i   = req_high ? 1'b1 : 1'($urandom_range(0, 1));
            bus_if.cpu_we_i    = 1'($urandom_range(0, 1));
            bus_if.cpu_addr_i  = $urandom;
            bus_if.cpu_wdata_i = $urandom;
            bus_if.cpu_sel_i   = 4'($urandom_range(0, 15));
            stepNeg();
            k++;
        end
        bus_if.cpu_req_i = 1'b0;
        bus_if.wb_data_i = $urandom;
        bus_if.wb_ack_i  = (acked && hold > 0) || (k == ack_cycle);
        stale_left       = (acked && hold > 1) ? 1 : 0;
    endtask

    // Monitor: compares every completion and every BUS cycle against the scoreboard.
    always @(negedge clk_i) begin : monitor
        exp_txn_t cur;
        if (rst) begin
            bus_count = 0;
            checkOutput("done_in_reset", bus_if.cpu_done_o, 1'b0);
        end else begin
            if (bus_if.wb_stb_o) begin
                bus_count++;
                if (exp_q.size() == 0) begin
                    checkOutput("stb_without_request", bus_if.wb_stb_o, 1'b0);
                end else begin
                    cur = exp_q[0];
                    checkOutput("wb_addr", bus_if.wb_addr_o, cur.addr);
                    checkOutput("wb_data", bus_if.wb_data_o, cur.wdata);
                    checkOutput("wb_we", bus_if.wb_we_o, cur.we);
                    checkOutput("wb_sel", bus_if.wb_sel_o, cur.sel);
                end
            end
            checkOutput("cyc_eq_stb", bus_if.wb_cyc_o, bus_if.wb_stb_o);
            checkOutput("busy", bus_if.cpu_busy_o, bus_if.wb_stb_o | bus_if.cpu_done_o);
            if (bus_if.cpu_done_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("done_without_request", bus_if.cpu_done_o, 1'b0);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("cpu_err", bus_if.cpu_err_o, cur.err);
                    checkOutput("cpu_rdata", bus_if.cpu_rdata_o, cur.rdata);
                    checkOutput("bus_cycles", bus_count, cur.bus_cycles);
                end
                bus_count = 0;
            end else begin
                checkOutput("err_without_done", bus_if.cpu_err_o, 1'b0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        exp_txn_t t;
        bit       b2b;
        int       wait_cycles;
        int       r;
        int       ack_cycle;
        bus_if.cpu_req_i   = 1'b1;
        bus_if.cpu_we_i    = 1'b1;
        bus_if.cpu_addr_i  = 32'h1234_5678;
        bus_if.cpu_wdata_i = 32'h9ABC_DEF0;
        bus_if.cpu_sel_i   = 4'hF;
        bus_if.wb_data_i   = 32'hFFFF_FFFF;
        bus_if.wb_ack_i    = 1'b1;

        repeat (3) stepNeg();
        checkOutput("rst_cyc", bus_if.wb_cyc_o, 1'b0);
        checkOutput("rst_stb", bus_if.wb_stb_o, 1'b0);
        checkOutput("rst_busy", bus_if.cpu_busy_o, 1'b0);
        checkOutput("rst_done", bus_if.cpu_done_o, 1'b0);
        checkOutput("rst_err", bus_if.cpu_err_o, 1'b0);
        checkOutput("rst_rdata", bus_if.cpu_rdata_o, 32'd0);
        checkOutput("rst_addr", bus_if.wb_addr_o, 32'd0);
        checkOutput("rst_wdata", bus_if.wb_data_o, 32'd0);
        checkOutput("rst_we", bus_if.wb_we_o, 1'b0);
        checkOutput("rst_sel", bus_if.wb_sel_o, 4'd0);
        rst              = 1'b0;
        bus_if.cpu_req_i = 1'b0;
        bus_if.wb_ack_i  = 1'b0;
        stepNeg();
        checkOutput("idle_after_rst", bus_if.cpu_busy_o, 1'b0);

        // Read acked in the second BUS cycle.
        applyStimulus(1'b0, 32'h1000_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, 2, 0, 1, 1'b0);
        stepNeg();
        // Write acked at once; read data must survive.
        applyStimulus(1'b1, 32'h1000_0008, 32'h0000_00A5, 4'h1, 32'h5555_AAAA, 1, 0, 1, 1'b0);
        stepNeg();
        // Silent slave: full timeout window.
        applyStimulus(1'b0, 32'h2000_0000, 32'h0, 4'hF, 32'h0BAD_F00D, 99, 0, 1, 1'b0);
        stepNeg();
        // Ack in the last allowed cycle wins over the timeout.
        applyStimulus(1'b0, 32'h2000_0010, 32'h0, 4'hC, 32'hCAFE_0001, TMO, 0, 1, 1'b0);
        stepNeg();
        // Ack held three cycles with request held high, then back-to-back.
        applyStimulus(1'b0, 32'h3000_0000, 32'h0, 4'h3, 32'h1111_2222, 1, 2, 1, 1'b1);
        applyStimulus(1'b1, 32'h3000_0004, 32'h7777_8888, 4'hF, 32'h3333_4444, 2, 2, 2, 1'b1);
        applyStimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h4444_5555, 3, 0, 2, 1'b1);
        stepNeg();
        // Late ack arriving during DONE after a timeout.
        applyStimulus(1'b0, 32'h4000_0000, 32'h0, 4'hF, 32'h6666_7777, TMO + 1, 0, 1, 1'b0);
        stepNeg();
        stepNeg();

        // Reset in the middle of BUS, with a request held during reset.
        t.we = 1'b0; t.addr = 32'h5000_0000; t.wdata = 32'h0; t.sel = 4'hF;
        t.err = 1'b0; t.rdata = 32'h0; t.bus_cycles = 0;
        exp_q.push_back(t);
        bus_if.cpu_req_i   = 1'b1;
        bus_if.cpu_we_i    = t.we;
        bus_if.cpu_addr_i  = t.addr;
        bus_if.cpu_wdata_i = t.wdata;
        bus_if.cpu_sel_i   = t.sel;
        stepNeg();
        checkOutput("rst_test_stb", bus_if.wb_stb_o, 1'b1);
        stepNeg();
        rst = 1'b1;
        exp_q.delete();
        stepNeg();
        checkOutput("mid_rst_cyc", bus_if.wb_cyc_o, 1'b0);
        checkOutput("mid_rst_stb", bus_if.wb_stb_o, 1'b0);
        checkOutput("mid_rst_busy", bus_if.cpu_busy_o, 1'b0);
        stepNeg();
        rst              = 1'b0;
        bus_if.cpu_req_i = 1'b0;
        model_rdata      = 32'd0;
        stepNeg();
        checkOutput("req_ignored_in_rst", bus_if.cpu_busy_o, 1'b0);
        applyStimulus(1'b0, 32'h5000_0004, 32'h0, 4'hF, 32'h0123_4567, 3, 0, 1, 1'b0);

        // Randomized traffic.
        b2b = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!b2b) begin
                wait_cycles = $urandom_range(1, 3);
                repeat (wait_cycles) stepNeg();
            end
            r = $urandom_range(0, 9);
            ack_cycle = (r < 6) ? r + 1 : 99;
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          4'($urandom_range(0, 15)), $urandom, ack_cycle,
                          $urandom_range(0, 2), b2b ? 2 : 1, 1'($urandom_range(0, 1)));
            b2b = 1'($urandom_range(0, 1));
        end

        repeat (4) stepNeg();
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
